mem_fifo_ctrl: RTL

//   FIFO controller that turns one single-port, async-read memory core (mem_core) into a

---
 rtl/mem_fifo_ctrl.sv | 85 ++++++++
 1 files changed

// File: rtl/mem_fifo_ctrl.sv
// Stream FIFO controller around a single-port, async-read memory core.
// Adds a one-entry output register so capacity is Depth+1 and empty pushes bypass memory.
module mem_fifo_ctrl #(
    parameter int ElemWidth = 8,
    parameter int AddrWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ElemWidth-1:0] data_in_i,
    input  logic                 data_in_valid_i,
    output logic                 data_in_ready_o,
    output logic [ElemWidth-1:0] data_out_o,
    output logic                 data_out_valid_o,
    input  logic                 data_out_ready_i,
    output logic [AddrWidth:0]   count_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [ElemWidth-1:0] mem_wdata_o,
    input  logic [ElemWidth-1:0] mem_rdata_i
);

    localparam logic [AddrWidth:0] DepthCnt = {1'b1, {AddrWidth{1'b0}}};

    logic [AddrWidth-1:0] wr_ptr;
    logic [AddrWidth-1:0] rd_ptr;
    logic [AddrWidth:0]   mem_cnt;
    logic                 out_vld;
    logic [ElemWidth-1:0] out_data;

    logic pop;
    logic out_free;
    logic mem_empty;
    logic refill;
    logic push;
    logic bypass;
    logic push_mem;

    assign pop       = out_vld && data_out_ready_i;
    assign out_free  = !out_vld || pop;
    assign mem_empty = (mem_cnt == '0);
    assign refill    = !mem_empty && out_free;

    // Ready never looks at data_in_valid_i, so the producer sees no combinational loop.
    assign data_in_ready_o = !rst_i && !refill && (mem_cnt != DepthCnt);
    assign push            = data_in_valid_i && data_in_ready_o;
    assign bypass          = push && mem_empty && out_free;
    assign push_mem        = push && !bypass;

    assign mem_we_o    = push_mem;
    assign mem_addr_o  = refill ? rd_ptr : wr_ptr;
    assign mem_wdata_o = data_in_i;

    assign data_out_o       = out_data;
    assign data_out_valid_o = out_vld;
    assign count_o          = mem_cnt + {{AddrWidth{1'b0}}, out_vld};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
        end else begin
            if (refill) begin
                out_data <= mem_rdata_i;
                out_vld  <= 1'b1;
                rd_ptr   <= rd_ptr + AddrWidth'(1);
                mem_cnt  <= mem_cnt - (AddrWidth + 1)'(1);
            end else if (bypass) begin
                out_data <= data_in_i;
                out_vld  <= 1'b1;
            end else if (pop) begin
                out_vld <= 1'b0;
            end

            // Refill and memory push are exclusive because ready is low during refill.
            if (push_mem) begin
                wr_ptr  <= wr_ptr + AddrWidth'(1);
                mem_cnt <= mem_cnt + (AddrWidth + 1)'(1);
            end
        end
    end

endmodule
